// File: rtl/pic_cascade_pkg.sv
// Shared types and constants for the PIC cascade / INTA sequencer.
package pic_cascade_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_G1,
    ST_P2,
    ST_G2,
    ST_P3
  } seq_state_e;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  // ADI selects the 8080 call-table stride: 4-byte or 8-byte entries.
  localparam logic ADI_4       = 1'b1;
  localparam logic ADI_8       = 1'b0;
  localparam int   ADI_4_SHIFT = 2;
  localparam int   ADI_8_SHIFT = 3;

endpackage

// File: rtl/pic_cascade_ctrl_inta_sync_edge.sv
// INTA_N synchroniser with registered fall/rise pulses, two CLK from pin to pulse.
module inta_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic s1, s2;

  // Edge is taken between the two stages so the pulse lands two CLK after the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= inta_n;
      s2   <= s1;
      fall <= s2 & ~s1;
      rise <= ~s2 & s1;
    end
  end

endmodule

// File: rtl/pic_cascade_ctrl.sv
// INTA-cycle sequencer: cascade address drive/decode and vector byte steering.
module pic_cascade_ctrl
  import pic_cascade_pkg::*;
#(
  parameter  int N_IRQ = 8,
  parameter  int CAS_W = 3,
  localparam int IRQ_W = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sngl,
  input  logic             sp_en,
  input  logic             mode_8086,
  input  logic [N_IRQ-1:0] icw3,
  input  logic [7:0]       icw2,
  input  logic [2:0]       icw1_a,
  input  logic             adi,
  input  logic             inta_n,
  input  logic             irq_valid,
  input  logic [IRQ_W-1:0] irq_id,
  input  logic [CAS_W-1:0] cas_in,
  output logic [CAS_W-1:0] cas_out,
  output logic             cas_oe,
  output logic [7:0]       data_out,
  output logic             data_oe,
  output logic             isr_set,
  output logic [IRQ_W-1:0] ack_id,
  output logic             ack_done
);

  if ((1 << CAS_W) < N_IRQ) begin : g_cas_w_chk
    $error("CAS_W too narrow to address N_IRQ slaves");
  end
  if (N_IRQ < 2 || N_IRQ > 64 || (N_IRQ & (N_IRQ - 1)) != 0) begin : g_n_irq_chk
    $error("N_IRQ must be a power of two in 2..64");
  end

  a_mode_8080: assert property (@(posedge clk) disable iff (!rst_n) (N_IRQ == 8) || mode_8086);

  logic inta_fall, inta_rise;

  inta_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .inta_n (inta_n),
    .fall   (inta_fall),
    .rise   (inta_rise)
  );

  seq_state_e       state;
  logic             c_sngl, c_sp_en, c_mode, c_adi, c_casc, sel;
  logic [7:0]       c_icw2;
  logic [2:0]       c_icw1_a;
  logic [CAS_W-1:0] c_own_id;

  // Sequence-start decode works from live inputs; everything later uses the context.
  logic [IRQ_W-1:0] ack_nxt;
  logic             casc_nxt, drive_p1;
  logic             is_slave, own_data, slv_hit;
  logic [7:0]       byte_p2;

  always_comb begin
    ack_nxt  = irq_valid ? irq_id : IRQ_W'(N_IRQ - 1);
    casc_nxt = !sngl && sp_en && icw3[ack_nxt];
    drive_p1 = !mode_8086 && (sngl || sp_en);
    is_slave = !c_sngl && !c_sp_en;
    own_data = c_sngl || (c_sp_en && !c_casc);
    slv_hit  = (cas_in == c_own_id);
    if (c_mode)
      byte_p2 = (c_icw2 & ~8'(N_IRQ - 1)) | 8'(ack_id);
    else if (c_adi == ADI_4)
      byte_p2 = {c_icw1_a, 5'b0} | (8'(ack_id) << ADI_4_SHIFT);
    else
      byte_p2 = {c_icw1_a[2:1], 6'b0} | (8'(ack_id) << ADI_8_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      c_sngl   <= 1'b0;
      c_sp_en  <= 1'b0;
      c_mode   <= 1'b0;
      c_adi    <= 1'b0;
      c_casc   <= 1'b0;
      c_icw2   <= '0;
      c_icw1_a <= '0;
      c_own_id <= '0;
      sel      <= 1'b0;
      cas_out  <= '0;
      cas_oe   <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
      isr_set  <= 1'b0;
      ack_id   <= '0;
      ack_done <= 1'b0;
    end else begin
      isr_set  <= 1'b0;
      ack_done <= 1'b0;
      case (state)
        ST_IDLE: if (inta_fall) begin
          state    <= ST_P1;
          c_sngl   <= sngl;
          c_sp_en  <= sp_en;
          c_mode   <= mode_8086;
          c_adi    <= adi;
          c_icw2   <= icw2;
          c_icw1_a <= icw1_a;
          c_own_id <= CAS_W'(icw3);
          c_casc   <= casc_nxt;
          sel      <= 1'b0;
          ack_id   <= ack_nxt;
          isr_set  <= irq_valid;
          if (drive_p1) begin
            data_oe  <= 1'b1;
            data_out <= CALL_OPCODE;
          end
        end
        ST_P1: if (inta_rise) begin
          state    <= ST_G1;
          data_oe  <= 1'b0;
          data_out <= '0;
          cas_oe   <= c_casc;
          cas_out  <= c_casc ? CAS_W'(ack_id) : '0;
        end
        ST_G1: if (inta_fall) begin
          state <= ST_P2;
          sel   <= is_slave && slv_hit;
          if (own_data || (is_slave && slv_hit)) begin
            data_oe  <= 1'b1;
            data_out <= byte_p2;
          end
        end
        ST_P2: if (inta_rise) begin
          data_oe  <= 1'b0;
          data_out <= '0;
          if (c_mode) begin
            state    <= ST_IDLE;
            ack_done <= 1'b1;
            cas_oe   <= 1'b0;
            cas_out  <= '0;
          end else begin
            state <= ST_G2;
          end
        end
        ST_G2: if (inta_fall) begin
          state <= ST_P3;
          if (own_data || sel) begin
            data_oe  <= 1'b1;
            data_out <= c_icw2;
          end
        end
        ST_P3: if (inta_rise) begin
          state    <= ST_IDLE;
          ack_done <= 1'b1;
          data_oe  <= 1'b0;
          data_out <= '0;
          cas_oe   <= 1'b0;
          cas_out  <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pic_cascade_ctrl.md
# pic_cascade_ctrl

Parametrised, clocked successor to the PIC cascade logic: sequences the CPU interrupt-acknowledge (INTA) cycle, drives or decodes the cascade address bus, and steers vector bytes onto the data bus. It sits between the priority resolver / in-service logic and the data-bus buffer. It supports a generic IRQ count and cascade-ID width, single/master/slave roles, and both 8086 (two-pulse) and 8080 (three-pulse, CALL) acknowledge modes.

## Interface
- N_IRQ, 8: interrupt inputs per device; power of two, 2..64; IRQ_W = clog2(N_IRQ).
- CAS_W, 3: cascade-ID width; must satisfy 2**CAS_W >= N_IRQ.
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- SNGL  in  1  1 = single device, cascade logic idle.
- SP_EN  in  1  1 = master, 0 = slave.
- MODE_8086  in  1  1 = two-pulse 8086 mode, 0 = three-pulse 8080 mode (legal only when N_IRQ==8).
- ICW3  in  N_IRQ  master: slave-present mask per IR; slave: ICW3[CAS_W-1:0] = own ID.
- ICW2  in  8  vector base (8086) / call-address high byte (8080).
- ICW1_A  in  3  call-address bits A7..A5 (8080).
- ADI  in  1  8080 call-address interval: 1 = 4 bytes, 0 = 8 bytes.
- INTA_N  in  1  CPU acknowledge strobe, asynchronous, active-low.
- IRQ_VALID  in  1  resolver has a winning request.
- IRQ_ID  in  IRQ_W  winning IR index.
- CAS_IN  in  CAS_W  cascade bus as sampled at the pins.
- CAS_OUT  out  CAS_W  cascade address driven by master.
- CAS_OE  out  1  cascade bus output enable.
- DATA_OUT  out  8  byte for the data buffer.
- DATA_OE  out  1  data byte valid and must be driven.
- ISR_SET  out  1  1-CLK pulse: set in-service bit ACK_ID.
- ACK_ID  out  IRQ_W  IR index latched for this acknowledge.
- ACK_DONE  out  1  1-CLK pulse at the end of the last INTA pulse.

## Operation
- INTA_N is passed through a 2-flop synchroniser, then through a fall/rise edge detector.
- FSM states: IDLE, P1, G1, P2, G2, P3.
  - Pn = INTA_N low for pulse n; Gn = gap after pulse n.
- IDLE→P1 on fall. At this edge:
  - Latch IRQ_ID, SNGL, SP_EN, MODE_8086 and the ICWs into a sequence context. Config changes have no effect mid-sequence.
  - If IRQ_VALID=0, the sequence is spurious: ACK_ID = N_IRQ-1 and no ISR_SET. Otherwise pulse ISR_SET.
- Role decode at the latched context:
  - **Master, ICW3[ACK_ID]=1:** cascaded. CAS_OE=1 and CAS_OUT=ACK_ID[CAS_W-1:0] from P1 rise through the rise ending the last pulse. The master never drives vector bytes; in 8080 mode it drives only 0xCD on P1.
  - **Slave:** on the P2 fall, set `sel` when CAS_IN==ICW3[CAS_W-1:0]. It drives bytes only if `sel`=1. An unselected slave still walks the FSM silently.
  - **Single, or master with a non-cascaded IR:** drives all bytes itself.
- Bytes in 8086 mode:
  - P1: none.
  - P2: {ICW2[7:IRQ_W], ACK_ID}.
- Bytes in 8080 mode:
  - P1: 0xCD, from master or single only.
  - P2: ADI=1 gives {ICW1_A, ACK_ID, 2'b00}; ADI=0 gives {ICW1_A[2:1], ACK_ID, 3'b000}.
  - P3: ICW2.
- Transitions:
  - P1→G1 on rise.
  - G1→P2 on fall.
  - P2→G2 on rise. In 8086 mode this goes to IDLE instead, with ACK_DONE.
  - G2→P3 on fall.
  - P3→IDLE on rise, with ACK_DONE.
- CAS_OE is never asserted by a slave or in SNGL.

## Timing
- Latency: INTA_N pin edge → synchronised edge is 2 CLK; DATA_OE, CAS_OE and ISR_SET are registered, for 3 CLK total. Deassertion has the same latency.
- INTA_N low and high widths must each be ≥4 CLK. Shorter pulses are undefined.
- DATA_OE is high exactly while in the owning Pn state. DATA_OUT is stable for the whole assertion and is 0 otherwise.
- Reset (asynchronous, any state):
  - FSM=IDLE, context and `sel` cleared.
  - CAS_OE=0, CAS_OUT=0, DATA_OE=0, DATA_OUT=0, ISR_SET=0, ACK_DONE=0, ACK_ID=0.
- Reset mid-sequence must not produce ACK_DONE. After reset, the first fall seen starts a new sequence.
- A fall while in IDLE always starts P1. No timeout; the FSM waits indefinitely in Gn.

## Structure
- Package pic_cascade_pkg holds:
  - the FSM state enum;
  - CALL_OPCODE = 8'hCD;
  - the ADI interval constants.
- Sub-module inta_sync_edge: 2-flop synchroniser plus registered fall/rise pulses.
- Elaboration check: fail if !MODE-independent constraints hold.
  - It is an error if 2**CAS_W < N_IRQ.
  - A runtime assertion fires if MODE_8086=0 with N_IRQ != 8.

## Test plan
- Single, 8086, ICW2=0x40, IRQ_ID=5, two INTA pulses → ISR_SET once; P2 byte 0x45; ACK_DONE after second rise.
- Master, ICW3=0x08, IRQ_ID=3, 8086 → CAS_OUT=3, CAS_OE high from P1 rise to P2 rise; DATA_OE never asserted.
- Slave, ID=3: CAS_IN=3 → drives {ICW2[7:3],ACK_ID} on P2. CAS_IN=2 → DATA_OE stays 0 and ACK_DONE still pulses.
- Single, 8080, ICW1_A=3'b101, ADI=1, ICW2=0x12, IRQ_ID=6 → bytes 0xCD, 0xB8, 0x12 on P1/P2/P3.
- IRQ_VALID=0 at first fall, 8086, ICW2=0x40 → no ISR_SET; P2 byte 0x47.
- RST_N asserted during G1 of a master cascade → CAS_OE drops immediately; no ACK_DONE; next sequence completes normally.
